// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//   Hazard/flush/debug controller for a classic 5-stage pipeline. Produces the
//   per-stage register write enables, the IF/ID flush and the ID/EX bubble, and
//   runs a small debug state machine (HALT / RUN / STEP / MEM_WAIT).
//   All control outputs are combinational from the current state and inputs.
//
// Optional feature:
//   PIPE_CTRL_PERF_EN  -- when defined, adds saturating stall and flush
//                         counters; when undefined both counter outputs are 0.
//
// Ports:
//   i_clock        rising-edge clock
//   i_reset        asynchronous active-low reset
//   i_hazard       load-use hazard from decode
//   i_branch_taken EX-stage redirect
//   i_mem_req      MEM stage is accessing data memory
//   i_mem_ready    data memory completes the access this cycle
//   i_halt_instr   halt instruction in WB
//   i_dbg_run      debug run command (pulse, honoured only in HALT)
//   i_dbg_step     debug single-step command (pulse, honoured only in HALT)
//   o_pc_we, o_ifid_we, o_exmem_we, o_memwb_we  stage register write enables
//   o_ifid_flush   clear IF/ID to NOP
//   o_idex_bubble  load NOP into ID/EX
//   o_halted       controller is in HALT
//   o_stall_cnt    cycles (outside HALT) in which the PC was held
//   o_flush_cnt    cycles in which IF/ID was flushed
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int NB_CNT = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_hazard,
  input  logic              i_branch_taken,
  input  logic              i_mem_req,
  input  logic              i_mem_ready,
  input  logic              i_halt_instr,
  input  logic              i_dbg_run,
  input  logic              i_dbg_step,
  output logic              o_pc_we,
  output logic              o_ifid_we,
  output logic              o_exmem_we,
  output logic              o_memwb_we,
  output logic              o_ifid_flush,
  output logic              o_idex_bubble,
  output logic              o_halted,
  output logic [NB_CNT-1:0] o_stall_cnt,
  output logic [NB_CNT-1:0] o_flush_cnt
);

  typedef enum logic [1:0] {
    ST_HALT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STEP     = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_t;

  state_t state_reg, state_next;
  logic   step_pending_reg, step_pending_next;
  logic   issue; // pipeline is allowed to move this cycle (branch/hazard/advance rules apply)

  // State register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_reg        <= ST_HALT;
      step_pending_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      step_pending_reg <= step_pending_next;
    end
  end

  // Next-state and Mealy outputs
  always_comb begin
    state_next        = state_reg;
    step_pending_next = step_pending_reg;
    issue             = 1'b0;
    o_pc_we           = 1'b0;
    o_ifid_we         = 1'b0;
    o_exmem_we        = 1'b0;
    o_memwb_we        = 1'b0;
    o_ifid_flush      = 1'b0;
    o_idex_bubble     = 1'b0;
    o_halted          = (state_reg == ST_HALT);

    case (state_reg)
      ST_HALT: begin
        // run wins when both commands arrive together
        if (i_dbg_run)       state_next = ST_RUN;
        else if (i_dbg_step) state_next = ST_STEP;
      end
      ST_RUN, ST_STEP: begin
        if (i_mem_req && !i_mem_ready) begin
          // Freeze everything; remember whether we owe a return to HALT
          state_next        = ST_MEM_WAIT;
          step_pending_next = (state_reg == ST_STEP);
        end else begin
          issue      = 1'b1;
          state_next = (state_reg == ST_STEP) ? ST_HALT : ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        // branch/hazard are held off until the access completes
        if (i_mem_ready) begin
          issue             = 1'b1;
          state_next        = step_pending_reg ? ST_HALT : ST_RUN;
          step_pending_next = 1'b0;
        end
      end
      default: state_next = ST_HALT;
    endcase

    if (issue) begin
      if (i_branch_taken) begin
        // Redirect squashes both the fetched and decoded instruction;
        // a coincident hazard refers to a squashed instruction, so ignore it.
        o_pc_we       = 1'b1;
        o_ifid_we     = 1'b1;
        o_exmem_we    = 1'b1;
        o_memwb_we    = 1'b1;
        o_ifid_flush  = 1'b1;
        o_idex_bubble = 1'b1;
      end else if (i_hazard) begin
        // Hold front end, insert bubble, let the back end drain
        o_exmem_we    = 1'b1;
        o_memwb_we    = 1'b1;
        o_idex_bubble = 1'b1;
      end else begin
        o_pc_we    = 1'b1;
        o_ifid_we  = 1'b1;
        o_exmem_we = 1'b1;
        o_memwb_we = 1'b1;
      end
      // MEM/WB always moves on an issue cycle, so the halt instruction is
      // retired here and takes priority over the normal return state.
      if (i_halt_instr) state_next = ST_HALT;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [NB_CNT-1:0] stall_cnt_reg, flush_cnt_reg;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if ((state_reg != ST_HALT) && !o_pc_we && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (o_ifid_flush && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign o_stall_cnt = stall_cnt_reg;
  assign o_flush_cnt = flush_cnt_reg;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Directed testbench for pipeline_ctrl. Inputs are driven 1 ns after the
//   rising edge, outputs are sampled 1 ns later. Output vector packing:
//   {pc_we, ifid_we, exmem_we, memwb_we, ifid_flush, idex_bubble, halted}
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam int NB_CNT = 16;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [6:0] V_HALT  = 7'b0000001;
  localparam logic [6:0] V_FRZ   = 7'b0000000;
  localparam logic [6:0] V_ADV   = 7'b1111000;
  localparam logic [6:0] V_HAZ   = 7'b0011010;
  localparam logic [6:0] V_BR    = 7'b1111110;

  logic clk = 1'b0;
  logic i_reset, i_hazard, i_branch_taken, i_mem_req, i_mem_ready;
  logic i_halt_instr, i_dbg_run, i_dbg_step;
  logic o_pc_we, o_ifid_we, o_exmem_we, o_memwb_we;
  logic o_ifid_flush, o_idex_bubble, o_halted;
  logic [NB_CNT-1:0] o_stall_cnt, o_flush_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.NB_CNT(NB_CNT)) dut (
    .i_clock       (clk),
    .i_reset       (i_reset),
    .i_hazard      (i_hazard),
    .i_branch_taken(i_branch_taken),
    .i_mem_req     (i_mem_req),
    .i_mem_ready   (i_mem_ready),
    .i_halt_instr  (i_halt_instr),
    .i_dbg_run     (i_dbg_run),
    .i_dbg_step    (i_dbg_step),
    .o_pc_we       (o_pc_we),
    .o_ifid_we     (o_ifid_we),
    .o_exmem_we    (o_exmem_we),
    .o_memwb_we    (o_memwb_we),
    .o_ifid_flush  (o_ifid_flush),
    .o_idex_bubble (o_idex_bubble),
    .o_halted      (o_halted),
    .o_stall_cnt   (o_stall_cnt),
    .o_flush_cnt   (o_flush_cnt)
  );

  function automatic logic [6:0] outs();
    return {o_pc_we, o_ifid_we, o_exmem_we, o_memwb_we, o_ifid_flush, o_idex_bubble, o_halted};
  endfunction

  function automatic logic [NB_CNT-1:0] cexp(input int n);
    return PERF ? NB_CNT'(n) : '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_hazard = 0; i_branch_taken = 0; i_mem_req = 0; i_mem_ready = 0;
    i_halt_instr = 0; i_dbg_run = 0; i_dbg_step = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_reset = 0;
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1;
  endtask

  task automatic go_run();
    i_dbg_run = 1;
    tick();
    i_dbg_run = 0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    clear_inputs();
    i_reset = 0;
    #3;
    total_cnt++;
    if (outs() !== V_HALT) $display("FAIL reset_outs: got %b want %b", outs(), V_HALT);
    else begin pass_cnt++; $display("ok reset_outs %b", outs()); end
    total_cnt++;
    if ({o_stall_cnt, o_flush_cnt} !== '0)
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", o_stall_cnt, o_flush_cnt);
    else begin pass_cnt++; $display("ok reset_cnt 0/0"); end
    tick();
    i_reset = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      total_cnt++;
      if (outs() !== V_HALT) $display("FAIL idle_halt[%0d]: got %b want %b", i, outs(), V_HALT);
      else begin pass_cnt++; $display("ok idle_halt[%0d] %b", i, outs()); end
      tick();
    end
  endtask

  task automatic test_hazard();
    do_reset();
    go_run();
    i_hazard = 1;
    #1;
    total_cnt++;
    if (outs() !== V_HAZ) $display("FAIL hazard_cycle: got %b want %b", outs(), V_HAZ);
    else begin pass_cnt++; $display("ok hazard_cycle %b", outs()); end
    tick();
    i_hazard = 0;
    i_dbg_step = 1; // ignored outside HALT
    #1;
    total_cnt++;
    if (outs() !== V_ADV) $display("FAIL hazard_after: got %b want %b", outs(), V_ADV);
    else begin pass_cnt++; $display("ok hazard_after %b", outs()); end
    total_cnt++;
    if (o_stall_cnt !== cexp(1)) $display("FAIL hazard_stall_cnt: got %0d want %0d", o_stall_cnt, cexp(1));
    else begin pass_cnt++; $display("ok hazard_stall_cnt %0d", o_stall_cnt); end
    tick();
    i_dbg_step = 0;
    #1;
    total_cnt++;
    if (outs() !== V_ADV) $display("FAIL step_ignored_in_run: got %b want %b", outs(), V_ADV);
    else begin pass_cnt++; $display("ok step_ignored_in_run %b", outs()); end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    go_run();
    i_branch_taken = 1;
    i_hazard = 1;
    #1;
    total_cnt++;
    if (outs() !== V_BR) $display("FAIL branch_hazard: got %b want %b", outs(), V_BR);
    else begin pass_cnt++; $display("ok branch_hazard %b", outs()); end
    tick();
    clear_inputs();
    #1;
    total_cnt++;
    if ({o_flush_cnt, o_stall_cnt} !== {cexp(1), cexp(0)})
      $display("FAIL branch_cnts: got %0d/%0d want %0d/%0d", o_flush_cnt, o_stall_cnt, cexp(1), cexp(0));
    else begin pass_cnt++; $display("ok branch_cnts %0d/%0d", o_flush_cnt, o_stall_cnt); end
    total_cnt++;
    if (outs() !== V_ADV) $display("FAIL branch_after: got %b want %b", outs(), V_ADV);
    else begin pass_cnt++; $display("ok branch_after %b", outs()); end
    tick();
  endtask

  task automatic test_mem_step();
    do_reset();
    i_dbg_step = 1;
    tick();
    i_dbg_step = 0;
    i_mem_req = 1;
    for (int i = 0; i < 3; i++) begin
      // branch/hazard during the wait must have no effect
      i_branch_taken = (i == 1);
      i_hazard       = (i == 2);
      #1;
      total_cnt++;
      if (outs() !== V_FRZ) $display("FAIL step_mem_wait[%0d]: got %b want %b", i, outs(), V_FRZ);
      else begin pass_cnt++; $display("ok step_mem_wait[%0d] %b", i, outs()); end
      tick();
    end
    i_branch_taken = 0;
    i_hazard = 0;
    i_mem_ready = 1;
    #1;
    total_cnt++;
    if (outs() !== V_ADV) $display("FAIL step_mem_ready: got %b want %b", outs(), V_ADV);
    else begin pass_cnt++; $display("ok step_mem_ready %b", outs()); end
    tick();
    clear_inputs();
    #1;
    total_cnt++;
    if (outs() !== V_HALT) $display("FAIL step_mem_halt: got %b want %b", outs(), V_HALT);
    else begin pass_cnt++; $display("ok step_mem_halt %b", outs()); end
    total_cnt++;
    if ({o_stall_cnt, o_flush_cnt} !== {cexp(3), cexp(0)})
      $display("FAIL step_mem_cnts: got %0d/%0d want %0d/%0d", o_stall_cnt, o_flush_cnt, cexp(3), cexp(0));
    else begin pass_cnt++; $display("ok step_mem_cnts %0d/%0d", o_stall_cnt, o_flush_cnt); end
    tick();

    // RUN variant: hazard on the ready cycle, halt_instr ignored while frozen
    do_reset();
    go_run();
    i_mem_req = 1;
    i_halt_instr = 1;
    #1;
    total_cnt++;
    if (outs() !== V_FRZ) $display("FAIL run_mem_stall: got %b want %b", outs(), V_FRZ);
    else begin pass_cnt++; $display("ok run_mem_stall %b", outs()); end
    tick();
    i_halt_instr = 0;
    i_mem_ready = 1;
    i_hazard = 1;
    #1;
    total_cnt++;
    if (outs() !== V_HAZ) $display("FAIL run_mem_ready_hazard: got %b want %b", outs(), V_HAZ);
    else begin pass_cnt++; $display("ok run_mem_ready_hazard %b", outs()); end
    tick();
    clear_inputs();
    #1;
    total_cnt++;
    if (outs() !== V_ADV) $display("FAIL run_mem_back_to_run: got %b want %b", outs(), V_ADV);
    else begin pass_cnt++; $display("ok run_mem_back_to_run %b", outs()); end
    total_cnt++;
    if (o_stall_cnt !== cexp(2)) $display("FAIL run_mem_stall_cnt: got %0d want %0d", o_stall_cnt, cexp(2));
    else begin pass_cnt++; $display("ok run_mem_stall_cnt %0d", o_stall_cnt); end
    tick();
  endtask

  task automatic test_halt_instr();
    do_reset();
    go_run();
    i_halt_instr = 1;
    #1;
    total_cnt++;
    if (outs() !== V_ADV) $display("FAIL halt_instr_cycle: got %b want %b", outs(), V_ADV);
    else begin pass_cnt++; $display("ok halt_instr_cycle %b", outs()); end
    tick();
    #1;
    total_cnt++;
    if (outs() !== V_HALT) $display("FAIL halt_instr_halted: got %b want %b", outs(), V_HALT);
    else begin pass_cnt++; $display("ok halt_instr_halted %b", outs()); end
    tick();
    i_halt_instr = 0;
    i_dbg_run = 1;
    i_dbg_step = 1;
    tick();
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      #1;
      total_cnt++;
      if (outs() !== V_ADV) $display("FAIL run_and_step_run[%0d]: got %b want %b", i, outs(), V_ADV);
      else begin pass_cnt++; $display("ok run_and_step_run[%0d] %b", i, outs()); end
      tick();
    end
    // halt_instr retired during a hazard cycle (MEM/WB still moves)
    i_hazard = 1;
    i_halt_instr = 1;
    tick();
    clear_inputs();
    #1;
    total_cnt++;
    if (outs() !== V_HALT) $display("FAIL halt_on_hazard: got %b want %b", outs(), V_HALT);
    else begin pass_cnt++; $display("ok halt_on_hazard %b", outs()); end
    // plain single step: one advance cycle then HALT
    i_dbg_step = 1;
    tick();
    i_dbg_step = 0;
    #1;
    total_cnt++;
    if (outs() !== V_ADV) $display("FAIL step_cycle: got %b want %b", outs(), V_ADV);
    else begin pass_cnt++; $display("ok step_cycle %b", outs()); end
    tick();
    #1;
    total_cnt++;
    if (outs() !== V_HALT) $display("FAIL step_back_halt: got %b want %b", outs(), V_HALT);
    else begin pass_cnt++; $display("ok step_back_halt %b", outs()); end
    tick();
  endtask

  task automatic test_reset_mem_wait();
    do_reset();
    go_run();
    i_branch_taken = 1;
    tick();
    i_branch_taken = 0;
    i_hazard = 1;
    tick();
    i_hazard = 0;
    i_mem_req = 1;
    tick(); // now in MEM_WAIT
    #2;
    total_cnt++;
    if ({o_stall_cnt, o_flush_cnt} !== {cexp(2), cexp(1)})
      $display("FAIL pre_reset_cnts: got %0d/%0d want %0d/%0d", o_stall_cnt, o_flush_cnt, cexp(2), cexp(1));
    else begin pass_cnt++; $display("ok pre_reset_cnts %0d/%0d", o_stall_cnt, o_flush_cnt); end
    i_reset = 0;
    #1;
    total_cnt++;
    if (outs() !== V_HALT) $display("FAIL async_reset_outs: got %b want %b", outs(), V_HALT);
    else begin pass_cnt++; $display("ok async_reset_outs %b", outs()); end
    total_cnt++;
    if ({o_stall_cnt, o_flush_cnt} !== '0)
      $display("FAIL async_reset_cnts: got %0d/%0d want 0/0", o_stall_cnt, o_flush_cnt);
    else begin pass_cnt++; $display("ok async_reset_cnts 0/0"); end
    i_mem_ready = 1;
    repeat (2) tick();
    i_reset = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if (outs() !== V_HALT) $display("FAIL post_reset_idle[%0d]: got %b want %b", i, outs(), V_HALT);
      else begin pass_cnt++; $display("ok post_reset_idle[%0d] %b", i, outs()); end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    i_reset = 0;
    test_reset();
    test_hazard();
    test_branch();
    test_mem_step();
    test_halt_instr();
    test_reset_mem_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 SHALL have parameter NB_CNT, default 16, width of performance counters.
REQ-003 SHALL have ports:
- i_clock  in  1  rising-edge clock
- i_reset  in  1  asynchronous active-low reset
- i_hazard  in  1  load-use hazard flag from decode
- i_branch_taken  in  1  EX-stage redirect (branch/jump resolved taken)
- i_mem_req  in  1  MEM stage performing data access
- i_mem_ready  in  1  data memory completes access this cycle
- i_halt_instr  in  1  halt instruction in WB
- i_dbg_run  in  1  debug run command, one-cycle pulse
- i_dbg_step  in  1  debug single-step command, one-cycle pulse
- o_pc_we, o_ifid_we, o_exmem_we, o_memwb_we  out  1 each  stage register write enables
- o_ifid_flush  out  1  clear IF/ID to NOP
- o_idex_bubble  out  1  load NOP into ID/EX
- o_halted  out  1  controller in HALT
- o_stall_cnt  out  NB_CNT  stall-cycle counter
- o_flush_cnt  out  NB_CNT  flush-event counter

Function
REQ-004 SHALL implement states HALT, RUN, STEP, MEM_WAIT; outputs combinational (Mealy) from state and inputs, same-cycle.
REQ-005 "Advance" SHALL mean all four write enables = 1, flush = 0, bubble = 0.
REQ-006 HALT: all enables 0, o_halted = 1; i_dbg_run -> RUN; else i_dbg_step -> STEP; both asserted -> RUN.
REQ-007 RUN/STEP, priority 1: i_mem_req & ~i_mem_ready -> all enables 0, next MEM_WAIT; step_pending flag set when entered from STEP.
REQ-008 RUN/STEP, priority 2: i_branch_taken -> advance, plus o_ifid_flush = 1 and o_idex_bubble = 1; i_hazard ignored that cycle.
REQ-009 RUN/STEP, priority 3: i_hazard -> o_pc_we = 0, o_ifid_we = 0, o_idex_bubble = 1, o_exmem_we = o_memwb_we = 1.
REQ-010 RUN/STEP, otherwise: advance.
REQ-011 i_halt_instr sampled only in cycles where o_memwb_we = 1; then next state HALT (overrides STEP/RUN return).
REQ-012 STEP SHALL last exactly one cycle; next state HALT unless REQ-007 or no exit condition applies.
REQ-013 MEM_WAIT: all enables 0 while ~i_mem_ready; on i_mem_ready apply REQ-008..REQ-011 rules, next state HALT if step_pending else RUN; clear step_pending.
REQ-014 i_dbg_run / i_dbg_step SHALL be ignored outside HALT.
REQ-015 In MEM_WAIT, i_branch_taken and i_hazard SHALL have no effect until the i_mem_ready cycle.

Reset
REQ-016 i_reset low SHALL force HALT, step_pending = 0, counters = 0 immediately, regardless of clock.
REQ-017 During and after reset until a command: o_halted = 1, all enables 0, flush = 0, bubble = 0.
REQ-018 Reset mid-MEM_WAIT SHALL abandon the wait; no enable pulses on release.

Configuration
REQ-019 Macro PIPE_CTRL_PERF_EN defined: o_stall_cnt +1 each non-HALT cycle with o_pc_we = 0; o_flush_cnt +1 each cycle with o_ifid_flush = 1; both saturate at all-ones.
REQ-020 Macro undefined: no counter registers; o_stall_cnt and o_flush_cnt tied to 0.

Verification
REQ-021 Reset release, no commands 10 cycles -> o_halted = 1, all enables 0 throughout.
REQ-022 i_dbg_run, then i_hazard = 1 one cycle -> that cycle pc_we = ifid_we = 0, bubble = 1; with PERF_EN stall_cnt = 1.
REQ-023 RUN, i_branch_taken = 1 and i_hazard = 1 same cycle -> pc_we = 1, flush = 1, bubble = 1; flush_cnt = 1.
REQ-024 i_dbg_step, i_mem_req = 1 with i_mem_ready low 3 cycles -> enables 0 for 3 cycles, advance on ready cycle, then HALT; stall_cnt = 3.
REQ-025 RUN, i_halt_instr = 1 -> advance that cycle, o_halted = 1 next cycle; later i_dbg_run + i_dbg_step same cycle -> RUN.
REQ-026 Reset asserted during MEM_WAIT -> HALT and counters 0 asynchronously; no enable asserted after release.
